// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : RV32I memory-stage initiator (valid/ready word bus,
//                   byte strobes, load extension, misalign and timeout flags)
// Rev 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignedM,
  output logic        BusErrorM,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam bit          c_tmo_en   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] c_tmo_last = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [31:0] r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        w_access, w_illegal, w_tmo_hit, w_timeout;
  logic [31:0] w_wdata, w_load;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_access = MemReadM | MemWriteM;

  // Store takes priority when both request lines are set.
  always_comb begin
    w_illegal = 1'b0;
    if (MemWriteM) begin
      if (Funct3M >= 3'b011) w_illegal = 1'b1;
    end else if (Funct3M == 3'b011 || Funct3M == 3'b110 || Funct3M == 3'b111) begin
      w_illegal = 1'b1;
    end
    if (Funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00) w_illegal = 1'b1;
    if (Funct3M[1:0] == 2'b01 && ALUResultM[0])            w_illegal = 1'b1;
  end

  assign MisalignedM = w_access & w_illegal;
  assign StallM      = w_access & ~MisalignedM & (r_state != S_DONE);

  always_comb begin
    w_wdata = WriteDataM;
    w_wstrb = 4'b1111;
    case (Funct3M[1:0])
      2'b00: begin
        w_wdata = {4{WriteDataM[7:0]}};
        w_wstrb = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        w_wdata = {2{WriteDataM[15:0]}};
        w_wstrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = mem_rsp_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = mem_rsp_rdata[15:8];
      2'd2:    w_byte = mem_rsp_rdata[23:16];
      2'd3:    w_byte = mem_rsp_rdata[31:24];
      default: ;
    endcase
    w_half = r_off[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rsp_rdata;
    endcase
  end

  assign w_tmo_hit = c_tmo_en && (r_cnt == c_tmo_last);

  // Completion wins over a timeout landing in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: if (w_access && !w_illegal) w_next = S_REQ;
      S_REQ: begin
        if (mem_req_ready) begin
          w_next = mem_req_we ? S_DONE : S_WAIT;
        end else if (w_tmo_hit) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          w_next = S_DONE;
        end else if (w_tmo_hit) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt         <= 32'd0;
      r_f3          <= 3'd0;
      r_off         <= 2'd0;
      ReadDataM     <= 32'd0;
      BusErrorM     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= 32'd0;
      mem_req_wdata <= 32'd0;
      mem_req_wstrb <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          BusErrorM <= 1'b0;
          if (w_next == S_REQ) begin
            r_cnt         <= 32'd0;
            r_f3          <= Funct3M;
            r_off         <= ALUResultM[1:0];
            mem_req_valid <= 1'b1;
            mem_req_we    <= MemWriteM;
            mem_req_addr  <= {ALUResultM[31:2], 2'b00};
            mem_req_wdata <= MemWriteM ? w_wdata : 32'd0;
            mem_req_wstrb <= MemWriteM ? w_wstrb : 4'd0;
          end
        end
        S_REQ, S_WAIT: begin
          r_cnt <= r_cnt + 32'd1;
          if (r_state == S_REQ && mem_req_ready) begin
            mem_req_valid <= 1'b0;
          end else if (r_state == S_WAIT && mem_rsp_valid) begin
            ReadDataM <= w_load;
          end else if (w_timeout) begin
            mem_req_valid <= 1'b0;
            ReadDataM     <= 32'd0;
            BusErrorM     <= 1'b1;
          end
        end
        default: BusErrorM <= 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit : randomized + directed self-checking bench for
//                      load_store_unit against a transaction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int TMO = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, MisalignedM, BusErrorM;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  int n_total = 0;
  int n_bad   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .StallM(StallM), .MisalignedM(MisalignedM), .BusErrorM(BusErrorM),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_mis(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
    sz = (f3 % 4 == 2) ? 4 : (f3 % 4 == 1) ? 2 : 1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] sh, v;
    sh = w >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = sh & 32'hFF;   if (v >= 128)   v = v + 32'hFFFFFF00; end
      3'd1: begin v = sh & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF0000; end
      3'd4: v = sh & 32'hFF;
      3'd5: v = sh & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0;
    ALUResultM = 32'd0; WriteDataM = 32'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
  endtask

  task automatic run_op(input logic we, input logic re, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rword, input logic exp_tmo);
    logic        mis, load, accepted, done;
    logic [3:0]  estrb;
    logic [31:0] ewd, erd;
    int          stall_n, vcnt, rcnt, exp_stall, off;
    mis  = model_mis(we, f3, addr);
    load = re && !we;
    off  = addr % 4;
    case (f3 % 4)
      0:       begin ewd = (wd & 32'hFF) * 32'h01010101;   estrb = 4'(1 << off); end
      1:       begin ewd = (wd & 32'hFFFF) * 32'h00010001; estrb = (off >= 2) ? 4'd12 : 4'd3; end
      default: begin ewd = wd; estrb = 4'd15; end
    endcase
    if (load) begin ewd = 32'd0; estrb = 4'd0; end
    erd = model_load(f3, addr, rword);
    exp_stall = exp_tmo ? TMO + 1 : 2 + rdy_dly + (load ? 1 + rsp_dly : 0);

    @(negedge clk);
    MemReadM = re; MemWriteM = we; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    #1;
    chk("misaligned", MisalignedM, mis);
    if (mis) begin
      chk("mis_stall", StallM, 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("mis_noreq", mem_req_valid, 0);
      end
      idle_inputs();
      return;
    end
    chk("stall_first", StallM, 1);
    stall_n = 1; vcnt = 0; rcnt = 0; accepted = 1'b0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (StallM) begin
        stall_n++;
        if (mem_req_valid) begin
          if (accepted) chk("single_accept", mem_req_valid, 0);
          else begin
            chk("req_addr",  mem_req_addr, addr & 32'hFFFFFFFC);
            chk("req_we",    mem_req_we, we);
            chk("req_wdata", mem_req_wdata, ewd);
            chk("req_wstrb", mem_req_wstrb, estrb);
            if (vcnt >= rdy_dly) begin mem_req_ready = 1'b1; accepted = 1'b1; end
            vcnt++;
          end
        end else if (accepted && load) begin
          if (rcnt == rsp_dly) begin mem_rsp_valid = 1'b1; mem_rsp_rdata = rword; end
          rcnt++;
        end
      end else begin
        done = 1'b1;
        chk("done_valid", mem_req_valid, 0);
        chk("buserr", BusErrorM, exp_tmo);
        if (exp_tmo)   chk("rdata_tmo", ReadDataM, 32'd0);
        else if (load) chk("rdata", ReadDataM, erd);
        chk("stall_len", stall_n, exp_stall);
      end
    end
    chk("op_finished", done, 1);
    idle_inputs();
    @(negedge clk);
    chk("buserr_pulse", BusErrorM, 0);
    chk("idle_stall", StallM, 0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_rdata", ReadDataM, 0);
    chk("rst_buserr", BusErrorM, 0);
    chk("rst_wstrb", mem_req_wstrb, 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_stall", StallM, 0);
    rst_n = 1'b1;

    run_op(1, 0, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);  // SW
    run_op(1, 0, 3'd0, 32'h103, 32'h000000A5, 0, 0, 0, 0);  // SB lane 3
    run_op(1, 0, 3'd1, 32'h206, 32'h1234BEEF, 0, 0, 0, 0);  // SH upper
    run_op(0, 1, 3'd0, 32'h102, 0, 0, 2, 32'h00800000, 0);  // LB
    run_op(0, 1, 3'd4, 32'h102, 0, 0, 2, 32'h00800000, 0);  // LBU
    run_op(0, 1, 3'd1, 32'h102, 0, 1, 0, 32'h8001FFFF, 0);  // LH upper
    run_op(0, 1, 3'd2, 32'h102, 0, 0, 0, 0, 0);             // LW misaligned
    run_op(0, 1, 3'd7, 32'h100, 0, 0, 0, 0, 0);             // illegal load
    run_op(1, 0, 3'd3, 32'h100, 0, 0, 0, 0, 0);             // illegal store
    run_op(1, 0, 3'd2, 32'h40, 32'hCAFEF00D, 5, 0, 0, 0);   // ready low 5 cycles
    run_op(1, 1, 3'd0, 32'h41, 32'h0000005A, 0, 0, 0, 0);   // both set -> store
    run_op(0, 1, 3'd2, 32'h200, 0, 0, 1000, 32'h1, 1);      // no response -> timeout
    run_op(1, 0, 3'd2, 32'h300, 32'h11, 1000, 0, 0, 1);     // never ready -> timeout

    for (int i = 0; i < 80; i++) begin
      logic we, re;
      we = 1'($urandom_range(0, 1));
      re = we ? 1'($urandom_range(0, 1)) : 1'b1;
      run_op(we, re, 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0);
    end

    // Reset while waiting for read data abandons the access.
    @(negedge clk);
    MemReadM = 1'b1; Funct3M = 3'd2; ALUResultM = 32'h80; mem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("wait_stall", StallM, 1);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_valid", mem_req_valid, 0);
    chk("midrst_stall", StallM, 0);
    chk("midrst_rdata", ReadDataM, 0);
    run_op(0, 1, 3'd5, 32'h82, 0, 0, 0, 32'hF00D1234, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
